// File: rtl/warp_mem_slave.sv
// warp_mem_slave: Wishbone classic slave memory with byte-lane writes, registered reads,
// sticky out-of-range error capture and an acknowledged-transfer counter.
// Ports: wb_clk_i/wb_rst_n_i clock and async active-low reset; wb_adr_i/wb_stb_i/wb_we_i/
// wb_sel_i/wb_dat_i request; wb_dat_o/wb_ack_o response; clr_i clears the status outputs;
// err_o/err_adr_o sticky out-of-range flag and first bad address; acc_count_o transfer count.
// Optional macro WARP_MEM_WAIT_EN adds wait_i[3:0] and a WAIT state of wait_i cycles.
module warp_mem_slave #(
    parameter int          DEPTH  = 16384,
    parameter int          ADRW   = 14,
    parameter logic [31:0] BADVAL = 32'hDEADBEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [31:0] wb_adr_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        clr_i,
`ifdef WARP_MEM_WAIT_EN
    input  logic [3:0]  wait_i,
`endif
    output logic        err_o,
    output logic [31:0] err_adr_o,
    output logic [31:0] acc_count_o
);
`ifdef WARP_MEM_WAIT_EN
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
`else
    typedef enum logic {IDLE, ACK} state_t;
`endif
    state_t      state_q, state_d;
    logic        enter_ack;
    logic [31:0] req_adr, req_dat;
    logic        req_we;
    logic [3:0]  req_sel;
    logic        oor;
    logic [ADRW-1:0] idx;
    logic [31:0] mem [DEPTH];
    logic [31:0] rdat_q, err_adr_q, acc_q;
    logic        err_q;
`ifdef WARP_MEM_WAIT_EN
    logic [31:0] adr_q, wdat_q;
    logic        we_q;
    logic [3:0]  sel_q, cnt_q, cnt_d;
    // While waiting, the request comes from the values latched at capture
    assign req_adr = (state_q == WAIT) ? adr_q  : wb_adr_i;
    assign req_dat = (state_q == WAIT) ? wdat_q : wb_dat_i;
    assign req_we  = (state_q == WAIT) ? we_q   : wb_we_i;
    assign req_sel = (state_q == WAIT) ? sel_q  : wb_sel_i;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        enter_ack = 1'b0;
        case (state_q)
            IDLE: if (wb_stb_i) begin
                if (wait_i == 4'd0) begin
                    state_d   = ACK;
                    enter_ack = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = wait_i;
                end
            end
            WAIT: if (cnt_q == 4'd1) begin
                state_d   = ACK;
                enter_ack = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            adr_q  <= '0;
            wdat_q <= '0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (state_q == IDLE && wb_stb_i) begin
                adr_q  <= wb_adr_i;
                wdat_q <= wb_dat_i;
                we_q   <= wb_we_i;
                sel_q  <= wb_sel_i;
            end
        end
    end
`else
    // Without wait states the capture edge is also the edge entering ACK,
    // so the live bus values are the request
    assign req_adr = wb_adr_i;
    assign req_dat = wb_dat_i;
    assign req_we  = wb_we_i;
    assign req_sel = wb_sel_i;
    always_comb begin
        state_d   = (state_q == IDLE && wb_stb_i) ? ACK : IDLE;
        enter_ack = (state_q == IDLE) && wb_stb_i;
    end
`endif
    assign oor = |req_adr[31:ADRW+2];
    assign idx = req_adr[ADRW+1:2];
    // The array shares the reset process so no write can commit while reset is held
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= IDLE;
            rdat_q    <= '0;
            err_q     <= 1'b0;
            err_adr_q <= '0;
            acc_q     <= '0;
        end else begin
            state_q <= state_d;
            if (enter_ack && req_we && !oor)
                for (int b = 0; b < 4; b++)
                    if (req_sel[b]) mem[idx][8*b +: 8] <= req_dat[8*b +: 8];
            if (enter_ack && !req_we) rdat_q <= oor ? BADVAL : mem[idx];
            if (clr_i) begin
                err_q     <= 1'b0;
                err_adr_q <= '0;
            end else if (enter_ack && oor) begin
                err_q <= 1'b1;
                if (!err_q) err_adr_q <= req_adr;
            end
            acc_q <= clr_i ? '0 : acc_q + {31'b0, state_q == ACK};
        end
    end
    assign wb_ack_o    = (state_q == ACK);
    assign wb_dat_o    = rdat_q;
    assign err_o       = err_q;
    assign err_adr_o   = err_adr_q;
    assign acc_count_o = acc_q;
endmodule

// File: tb/tb_warp_mem_slave.sv
// tb_warp_mem_slave: scoreboard bench for warp_mem_slave (default build, no wait states).
module tb_warp_mem_slave;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr_i, dat_i;
    logic        stb_i, we_i, clr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_o, err_adr_o, acc_o;
    logic        ack_o, err_o;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        prev_ack = 1'b0;
    typedef struct { logic we; logic [31:0] dat; } exp_t;
    exp_t exp_q[$];

    warp_mem_slave dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .wb_adr_i    (adr_i),
        .wb_stb_i    (stb_i),
        .wb_we_i     (we_i),
        .wb_sel_i    (sel_i),
        .wb_dat_i    (dat_i),
        .wb_dat_o    (dat_o),
        .wb_ack_o    (ack_o),
        .clr_i       (clr_i),
`ifdef WARP_MEM_WAIT_EN
        .wait_i      (4'd0),
`endif
        .err_o       (err_o),
        .err_adr_o   (err_adr_o),
        .acc_count_o (acc_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ack_o) begin
            check("single_ack", {31'b0, prev_ack}, 32'd0);
            check("ack_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                if (!e.we) check("read_data", dat_o, e.dat);
            end
        end
        prev_ack = ack_o;
    end

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] exp, input logic clr);
        int n;
        @(posedge clk); #1;
        stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel; clr_i = clr;
        exp_q.push_back('{we, exp});
        n = 0;
        do begin @(negedge clk); n++; end while (!ack_o && n < 20);
        clr_i = 1'b0;
        check("ack_latency", n, 32'd2);
        @(posedge clk); #1;
        stb_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, last;
        rst_n = 1'b0; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h40; dat_i = 32'hFFFF_FFFF;
        sel_i = 4'hF; clr_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", ack_o, 32'd0);
        check("rst_err", err_o, 32'd0);
        check("rst_acc", acc_o, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        stb_i = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        // byte lanes
        xfer(1, 32'h40, 32'h11223344, 4'hF, 0, 0);
        xfer(1, 32'h40, 32'hAABBCCDD, 4'b0101, 0, 0);
        xfer(0, 32'h40, 0, 4'h0, 32'h11BB33DD, 0);
        check("lane_acc", acc_o, 32'd3);
        // sel=0 write leaves the word alone
        xfer(1, 32'h40, 32'hFFFFFFFF, 4'h0, 0, 0);
        xfer(0, 32'h40, 0, 4'h0, 32'h11BB33DD, 0);
        // read-after-write, back to back
        xfer(1, 32'h44, 32'hCAFEF00D, 4'hF, 0, 0);
        xfer(0, 32'h44, 0, 4'h0, 32'hCAFEF00D, 0);
        xfer(1, 32'h0, 32'h5A5A5A5A, 4'hF, 0, 0);
        for (int i = 0; i < 8; i++) xfer(1, 32'h100 + 4 * i, 32'h10000000 + i, 4'hF, 0, 0);
        // stb held high across 8 consecutive reads
        @(posedge clk); #1;
        stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h100;
        last = 0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{1'b0, 32'h10000000 + i});
            n = 0;
            do begin @(negedge clk); n++; end while (!ack_o && n < 20);
            if (i == 0) check("b2b_first", n, 32'd2);
            else check("b2b_gap", cyc - last, 32'd2);
            last = cyc;
            @(posedge clk); #1;
            adr_i = 32'h100 + 4 * (i + 1);
        end
        stb_i = 1'b0;
        check("b2b_acc", acc_o, 32'd24);
        // out of range
        xfer(0, 32'h00010000, 0, 4'h0, 32'hDEADBEEF, 0);
        check("oor_err", err_o, 32'd1);
        check("oor_adr", err_adr_o, 32'h00010000);
        xfer(1, 32'h00020000, 32'h12345678, 4'hF, 0, 0);
        check("oor_adr_sticky", err_adr_o, 32'h00010000);
        xfer(0, 32'h0, 0, 4'h0, 32'h5A5A5A5A, 0);
        check("oor_acc", acc_o, 32'd27);
        @(posedge clk); #1 clr_i = 1'b1;
        @(posedge clk); #1 clr_i = 1'b0;
        check("clr_err", err_o, 32'd0);
        check("clr_adr", err_adr_o, 32'd0);
        check("clr_acc", acc_o, 32'd0);
        // clear colliding with an error capture
        xfer(0, 32'h00030000, 0, 4'h0, 32'hDEADBEEF, 1);
        check("coll_err", err_o, 32'd0);
        check("coll_adr", err_adr_o, 32'd0);
        check("coll_acc", acc_o, 32'd1);
        // reset before the commit edge loses the write
        xfer(1, 32'h80, 32'h13579BDF, 4'hF, 0, 0);
        @(posedge clk); #1;
        stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h80; dat_i = 32'h2468ACE0; sel_i = 4'hF;
        @(negedge clk);
        rst_n = 1'b0; stb_i = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("rst2_acc", acc_o, 32'd0);
        xfer(0, 32'h80, 0, 4'h0, 32'h13579BDF, 0);
        // reset while ack is high drops it at once
        @(posedge clk); #1;
        stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h80;
        exp_q.push_back('{1'b0, 32'h13579BDF});
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_ack_drop", ack_o, 32'd0);
        check("rst_dat_clear", dat_o, 32'd0);
        stb_i = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
